// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - two-requester round-robin frame scheduler for a UART transmitter
module uart_tx_sched #(
  parameter int START_TMO  = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       done0,
  output logic       done1,
  output logic       tmo_err,
  output logic       tx_en,
  output logic [7:0] tx_dfifo,
  input  logic       tx_busy,
  output logic       grant
);

  // One shared counter serves both the start timeout and the inter-frame gap.
  localparam int CNT_MAX = (START_TMO > GAP_CYCLES) ? START_TMO : GAP_CYCLES;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'((START_TMO > 0) ? START_TMO - 1 : 0);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  // With no gap configured a finished frame returns straight to IDLE.
  localparam state_t AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [1:0]    full;
  logic [7:0]    buf0, buf1;
  logic          last, last_nxt;
  logic          pick;
  logic          grant_nxt;
  logic          tx_en_nxt;
  logic [7:0]    data_nxt;
  logic [1:0]    done_nxt;
  logic          tmo_nxt;

  assign req0_ready = ~full[0];
  assign req1_ready = ~full[1];

  // Holding buffers: load when empty and offered, empty on the frame-finished edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full <= 2'b00;
      buf0 <= 8'h00;
      buf1 <= 8'h00;
    end else begin
      if (req0_valid && !full[0]) begin
        full[0] <= 1'b1;
        buf0    <= req0_data;
      end else if (done_nxt[0]) begin
        full[0] <= 1'b0;
      end
      if (req1_valid && !full[1]) begin
        full[1] <= 1'b1;
        buf1    <= req1_data;
      end else if (done_nxt[1]) begin
        full[1] <= 1'b0;
      end
    end
  end

  // Round-robin choice: on a tie the requester not served last wins.
  always_comb begin
    pick = 1'b0;
    if (full == 2'b11) pick = ~last;
    else               pick = full[1];
  end

  // Next-state and next-output decode for the frame sequencer.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cnt_inc   = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);
    grant_nxt = grant;
    last_nxt  = last;
    data_nxt  = tx_dfifo;
    tx_en_nxt = 1'b0;
    done_nxt  = 2'b00;
    tmo_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if ((full != 2'b00) && !tx_busy) begin
          grant_nxt = pick;
          data_nxt  = pick ? buf1 : buf0;
          tx_en_nxt = 1'b1;
          cnt_nxt   = '0;
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == TMO_LAST) begin
          tmo_nxt   = 1'b1;
          done_nxt  = grant ? 2'b10 : 2'b01;
          cnt_nxt   = '0;
          state_nxt = AFTER_FRAME;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          done_nxt  = grant ? 2'b10 : 2'b01;
          last_nxt  = grant;
          cnt_nxt   = '0;
          state_nxt = AFTER_FRAME;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) state_nxt = IDLE;
        else                 cnt_nxt   = cnt_inc;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer state and shared counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Registered outputs; grant and last start at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_en    <= 1'b0;
      tx_dfifo <= 8'h00;
      grant    <= 1'b1;
      last     <= 1'b1;
      done0    <= 1'b0;
      done1    <= 1'b0;
      tmo_err  <= 1'b0;
    end else begin
      tx_en    <= tx_en_nxt;
      tx_dfifo <= data_nxt;
      grant    <= grant_nxt;
      last     <= last_nxt;
      done0    <= done_nxt[0];
      done1    <= done_nxt[1];
      tmo_err  <= tmo_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - self-checking bench for uart_tx_sched
module tb_uart_tx_sched;
  localparam int START_TMO  = 16;
  localparam int GAP_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       done0, done1, tmo_err, tx_en, tx_busy, grant;
  logic [7:0] tx_dfifo;

  uart_tx_sched #(.START_TMO(START_TMO), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .done0(done0), .done1(done1), .tmo_err(tmo_err),
    .tx_en(tx_en), .tx_dfifo(tx_dfifo), .tx_busy(tx_busy), .grant(grant)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // requester byte streams
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  // reference model state
  logic [1:0] m_full;
  logic [7:0] m_byte[2];
  logic       m_last, m_grant;
  logic [7:0] m_data;
  bit         frame_open, saw_busy;
  int         t_en, next_eval;
  logic       e_en, e_tmo;
  logic [1:0] e_done;
  logic [1:0] acc;

  // transmitter responder
  int mode;
  int lat_fix, dur_fix;
  int busy_start, busy_end;
  bit force_busy;

  typedef struct {
    int         cyc;
    logic       g;
    logic [7:0] b;
  } tx_rec_t;
  tx_rec_t tx_log[$];
  int      done_log[$];
  int      tmo_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_full = 2'b00; m_byte[0] = 8'h00; m_byte[1] = 8'h00;
    m_last = 1'b1; m_grant = 1'b1; m_data = 8'h00;
    frame_open = 0; saw_busy = 0; t_en = 0; next_eval = 0;
    e_en = 0; e_tmo = 0; e_done = 2'b00; acc = 2'b00;
  endtask

  task automatic finish_frame();
    e_done[m_grant] = 1'b1;
    m_full[m_grant] = 1'b0;
    frame_open = 0;
    next_eval  = cyc + 1 + GAP_CYCLES;
  endtask

  // Predicts the outputs of the next cycle from this cycle's inputs.
  task automatic model_step();
    int w;
    e_en = 0; e_tmo = 0; e_done = 2'b00;
    acc[0] = req0_valid && !m_full[0];
    acc[1] = req1_valid && !m_full[1];
    if (!frame_open) begin
      if (cyc >= next_eval && m_full != 2'b00 && !tx_busy) begin
        if (m_full == 2'b11) w = m_last ? 0 : 1;
        else                 w = m_full[1] ? 1 : 0;
        m_grant = w[0]; m_data = m_byte[w]; e_en = 1;
        frame_open = 1; t_en = cyc + 1; saw_busy = 0;
      end
    end else if (cyc >= t_en) begin
      if (!saw_busy) begin
        if (tx_busy) saw_busy = 1;
        else if (cyc - t_en == START_TMO - 1) begin
          e_tmo = 1;
          finish_frame();
        end
      end else if (!tx_busy) begin
        m_last = m_grant;
        finish_frame();
      end
    end
    if (acc[0]) begin m_full[0] = 1'b1; m_byte[0] = req0_data; end
    if (acc[1]) begin m_full[1] = 1'b1; m_byte[1] = req1_data; end
  endtask

  task automatic drive_reqs();
    req0_valid = (q0.size() > 0);
    req0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
    req1_valid = (q1.size() > 0);
    req1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
  endtask

  task automatic tick();
    int l, d;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("tx_en", 32'(tx_en), 32'(e_en));
    chk("tx_dfifo", 32'(tx_dfifo), 32'(m_data));
    chk("grant", 32'(grant), 32'(m_grant));
    chk("done0", 32'(done0), 32'(e_done[0]));
    chk("done1", 32'(done1), 32'(e_done[1]));
    chk("tmo_err", 32'(tmo_err), 32'(e_tmo));
    chk("req0_ready", 32'(req0_ready), 32'(!m_full[0]));
    chk("req1_ready", 32'(req1_ready), 32'(!m_full[1]));
    if (tx_en) begin
      tx_log.push_back('{cyc, grant, tx_dfifo});
      if (mode == 0) begin
        l = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
        d = (dur_fix >= 0) ? dur_fix : int'($urandom_range(1, 12));
        busy_start = cyc + l;
        busy_end   = busy_start + d;
      end
    end
    if (done0 || done1) done_log.push_back(cyc);
    if (tmo_err) tmo_cnt++;
    if (acc[0]) void'(q0.pop_front());
    if (acc[1]) void'(q1.pop_front());
    tx_busy = force_busy || (cyc >= busy_start && cyc < busy_end);
    drive_reqs();
  endtask

  task automatic clear_logs();
    tx_log.delete(); done_log.delete(); tmo_cnt = 0;
  endtask

  task automatic run_until_idle(input int bound, input string tag);
    int n = 0;
    while ((frame_open || m_full != 2'b00 || q0.size() > 0 || q1.size() > 0 || tx_busy) && n < bound) begin
      tick();
      n++;
    end
    chk({tag, "_idle_bound"}, 32'(n < bound), 32'd1);
    repeat (GAP_CYCLES + 2) tick();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_tx_dfifo", 32'(tx_dfifo), 32'd0);
    chk("rst_grant", 32'(grant), 32'd1);
    chk("rst_done0", 32'(done0), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    chk("rst_tmo_err", 32'(tmo_err), 32'd0);
    chk("rst_req0_ready", 32'(req0_ready), 32'd1);
    chk("rst_req1_ready", 32'(req1_ready), 32'd1);
    q0.delete(); q1.delete(); drive_reqs();
    force_busy = 0; busy_start = 0; busy_end = 0; tx_busy = 1'b0; mode = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
      chk("rst_hold_done", 32'({done1, done0}), 32'd0);
    end
    rstn = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, c0, c1, rounds;
    bit ok;
    logic [7:0] b0[3];
    logic [7:0] b1[3];

    rstn = 1'b0; tx_busy = 1'b0; mode = 0; lat_fix = -1; dur_fix = -1;
    force_busy = 0; busy_start = 0; busy_end = 0; tmo_cnt = 0;
    drive_reqs();
    model_reset();
    do_reset();

    // single byte with a 10-cycle busy window
    lat_fix = 1; dur_fix = 10; clear_logs();
    t0 = cyc;
    q0.push_back(8'hA5); drive_reqs();
    run_until_idle(200, "single");
    chk("single_frames", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() == 1) begin
      chk("single_byte", 32'(tx_log[0].b), 32'hA5);
      chk("single_en_cycle", 32'(tx_log[0].cyc), 32'(t0 + 2));
    end
    chk("single_dones", 32'(done_log.size()), 32'd1);
    if (done_log.size() == 1) chk("single_done_after_fall", 32'(done_log[0]), 32'(busy_end + 1));

    // contention right after reset
    do_reset();
    lat_fix = -1; dur_fix = -1; clear_logs();
    q0.push_back(8'h11); q1.push_back(8'h22); drive_reqs();
    run_until_idle(200, "contend");
    chk("contend_frames", 32'(tx_log.size()), 32'd2);
    if (tx_log.size() == 2) begin
      chk("contend_g0", 32'(tx_log[0].g), 32'd0);
      chk("contend_b0", 32'(tx_log[0].b), 32'h11);
      chk("contend_g1", 32'(tx_log[1].g), 32'd1);
      chk("contend_b1", 32'(tx_log[1].b), 32'h22);
    end

    // fairness with both requesters continuously valid
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      b0[i] = 8'($urandom); b1[i] = 8'($urandom);
      q0.push_back(b0[i]); q1.push_back(b1[i]);
    end
    drive_reqs();
    run_until_idle(400, "fair");
    chk("fair_frames", 32'(tx_log.size()), 32'd6);
    c0 = 0; c1 = 0;
    for (int i = 0; i < tx_log.size(); i++) begin
      if (i > 0) chk("fair_alternate", 32'(tx_log[i].g != tx_log[i-1].g), 32'd1);
      if (tx_log[i].g == 1'b0 && c0 < 3) begin chk("fair_byte0", 32'(tx_log[i].b), 32'(b0[c0])); c0++; end
      else if (tx_log[i].g == 1'b1 && c1 < 3) begin chk("fair_byte1", 32'(tx_log[i].b), 32'(b1[c1])); c1++; end
    end
    chk("fair_count0", 32'(c0), 32'd3);
    chk("fair_count1", 32'(c1), 32'd3);

    // busy already high in IDLE blocks launch
    clear_logs();
    force_busy = 1; tx_busy = 1'b1;
    q1.push_back(8'h5C); drive_reqs();
    repeat (10) tick();
    chk("blocked_no_launch", 32'(tx_log.size()), 32'd0);
    force_busy = 0;
    run_until_idle(200, "blocked");
    chk("blocked_frames", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() == 1) chk("blocked_byte", 32'(tx_log[0].b), 32'h5C);

    // start timeout: transmitter never raises busy
    clear_logs();
    mode = 1;
    q0.push_back(8'($urandom)); q1.push_back(8'($urandom)); drive_reqs();
    run_until_idle(300, "tmo");
    chk("tmo_pulses", 32'(tmo_cnt), 32'd2);
    chk("tmo_frames", 32'(tx_log.size()), 32'd2);
    if (tx_log.size() >= 1 && done_log.size() >= 1)
      chk("tmo_latency", 32'(done_log[0] - tx_log[0].cyc), 32'(START_TMO));
    mode = 0;

    // inter-frame gap on back-to-back frames
    clear_logs();
    for (int i = 0; i < 3; i++) q0.push_back(8'($urandom));
    drive_reqs();
    run_until_idle(300, "gap");
    chk("gap_frames", 32'(tx_log.size()), 32'd3);
    if (tx_log.size() == 3 && done_log.size() >= 2) begin
      for (int i = 0; i < 2; i++)
        chk("gap_spacing", 32'(tx_log[i+1].cyc - done_log[i]), 32'(GAP_CYCLES + 1));
    end

    // randomized traffic, occasionally with a dead transmitter
    rounds = 15;
    for (int r = 0; r < rounds; r++) begin
      mode = ($urandom_range(0, 4) == 0) ? 1 : 0;
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) q0.push_back(8'($urandom));
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) q1.push_back(8'($urandom));
      drive_reqs();
      repeat (int'($urandom_range(0, 3))) tick();
      run_until_idle(600, "rand");
    end
    mode = 0;

    // reset while in WAIT_DONE with both buffers full
    clear_logs();
    lat_fix = 0; dur_fix = 30;
    q0.push_back(8'h3C); q1.push_back(8'hC3); drive_reqs();
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (frame_open && saw_busy && m_full == 2'b11) begin ok = 1; break; end
    end
    chk("rst_reach_wait_done", 32'(ok), 32'd1);
    tick();
    clear_logs();
    do_reset();
    lat_fix = -1; dur_fix = -1;
    repeat (6) tick();
    chk("rst_no_done", 32'(done_log.size()), 32'd0);
    chk("rst_no_launch", 32'(tx_log.size()), 32'd0);
    q1.push_back(8'h7E); drive_reqs();
    run_until_idle(200, "post_rst");
    chk("post_rst_frames", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() == 1) chk("post_rst_grant", 32'(tx_log[0].g), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter START_TMO, default 16: max cycles allowed from tx_en pulse to tx_busy rising.
REQ-002 SHALL have parameter GAP_CYCLES, default 0: idle cycles inserted between consecutive frames.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0_valid, req1_valid  input  1 each  requester byte offered.
REQ-006 SHALL have ports req0_data, req1_data  input  8 each  requester byte.
REQ-007 SHALL have ports req0_ready, req1_ready  output  1 each  requester holding buffer empty.
REQ-008 SHALL have ports done0, done1  output  1 each  one-cycle pulse, requester frame finished.
REQ-009 SHALL have port tmo_err  output  1  one-cycle pulse, transmitter failed to start.
REQ-010 SHALL have port tx_en  output  1  one-cycle frame start pulse to the UART transmitter.
REQ-011 SHALL have port tx_dfifo  output  8  byte presented to the UART transmitter.
REQ-012 SHALL have port tx_busy  input  1  UART transmitter busy flag.
REQ-013 SHALL have port grant  output  1  index of the requester currently or last served.

Function
REQ-014 SHALL keep one 8-bit holding buffer per requester; reqN_ready = ~bufN_full.
REQ-015 SHALL load bufN on a rising edge with reqN_valid && reqN_ready; bufN_full is set after that edge.
REQ-016 SHALL clear bufN_full only on the edge that pulses doneN. Because ready is low while the buffer is full, load and clear never coincide, and a new byte is accepted no earlier than the cycle after doneN.
REQ-017 SHALL implement the FSM states IDLE, WAIT_BUSY, WAIT_DONE and GAP.
REQ-018 IDLE: if any buffer is full and tx_busy==0, the FSM SHALL select a requester, register tx_en=1 and tx_dfifo=selected byte, load grant, and move to WAIT_BUSY. Otherwise it SHALL stay in IDLE.
REQ-019 Selection SHALL be round-robin. With both buffers full, the requester other than the last served wins; with one full, that one wins.
REQ-020 tx_en SHALL be high for exactly one cycle, the cycle after the IDLE decision; this is one cycle after byte acceptance when the channel is idle.
REQ-021 tx_dfifo SHALL hold the granted byte from the tx_en cycle until the FSM leaves WAIT_DONE.
REQ-022 WAIT_BUSY: a cycle counter SHALL run from 0. On tx_busy==1 the FSM SHALL move to WAIT_DONE. If the counter reaches START_TMO-1 with tx_busy still 0, the FSM SHALL pulse tmo_err and doneN for the grantee, clear that buffer (byte dropped), and go to GAP.
REQ-023 WAIT_DONE: on tx_busy==0 the FSM SHALL pulse doneN for the grantee, clear its buffer, record it as last served, and go to GAP.
REQ-024 GAP: the FSM SHALL stay GAP_CYCLES cycles, then return to IDLE. With GAP_CYCLES==0, GAP SHALL last zero cycles, i.e. a direct transition to IDLE.
REQ-025 tx_busy already high in IDLE SHALL block launch until it falls.
REQ-026 The counter SHALL be wide enough for max(START_TMO, GAP_CYCLES) and SHALL saturate, never wrap.
REQ-027 At most one doneN SHALL pulse per cycle, and tx_en SHALL never pulse outside IDLE-to-WAIT_BUSY.

Reset
REQ-028 On rstn low, asynchronously: state=IDLE, buffers empty, counter=0, tx_en=0, tx_dfifo=8'h00, done0=done1=0, tmo_err=0, grant=1 (so requester 0 wins the first tie), reqN_ready=1.
REQ-029 Reset mid-frame SHALL discard both buffered bytes with no done pulses; the first frame after reset release SHALL follow REQ-018.

Verification
REQ-030 Single byte: req0 sends 8'hA5 while idle -> tx_en one cycle later with tx_dfifo=8'hA5. With tx_busy high for 10 cycles, done0 pulses the cycle after tx_busy falls, and req0_ready returns to 1.
REQ-031 Contention: both requesters load in the same cycle (8'h11, 8'h22) after reset -> 8'h11 is sent first, then 8'h22; grant sequence is 0 then 1.
REQ-032 Fairness: req0 and req1 both kept continuously valid for 6 frames -> tx_dfifo strictly alternates the two requesters' bytes, 3 frames each.
REQ-033 Timeout: tx_busy held 0 after tx_en -> tmo_err and done0 pulse exactly START_TMO cycles after tx_en, and the next frame launches.
REQ-034 Gap: GAP_CYCLES=4 with back-to-back frames -> exactly 4 cycles between done and the next tx_en condition evaluation.
REQ-035 Reset in WAIT_DONE with both buffers full -> all outputs at REQ-028 values, no done pulse, and both readys are 1 after release.
